// File: rtl/phy_tx_serial_if.sv
// Byte-side handshake and serial-side outputs of one transmitter lane.
//
// Handshake: ready_out is high in the cycle before a load edge once the
// preamble is done. A byte is taken on that rising edge only if valid_in=1
// at the same time. valid_in raised while ready_out=0 is ignored, and the
// byte is not held for later. There is no backpressure beyond this.
interface phy_tx_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic       state_dbg;   // current FSM state: 0 = SYNC, 1 = ACTIVE

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, active_out, state_dbg
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, active_out, state_dbg
  );
endinterface

// File: rtl/phy_tx_serial.sv
// Per-lane parallel-to-serial transmitter. Bytes go out MSB first, one bit
// per clk_8f cycle. After reset it sends a comma preamble so the receiver
// can align. After that, a load slot with no valid byte sends a comma.
module phy_tx_serial #(
  parameter logic [7:0] IDLE_SYMBOL  = 8'hBC,
  parameter int         SYNC_SYMBOLS = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  phy_tx_serial_if.slave   bus
);

  localparam int SW = (SYNC_SYMBOLS < 1) ? 1 : $clog2(SYNC_SYMBOLS + 1);
  localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_SYMBOLS - 1);

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state, state_d;
  logic [SW-1:0] sync_cnt, sync_cnt_d;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          load;
  logic [7:0]    load_byte;

  // A load edge is every eighth edge. bit_cnt resets to 7, so the first
  // edge after reset is a load edge.
  assign load = (bit_cnt == 3'd7);

  // Comma during the preamble. After that, the user byte if valid, else a comma.
  assign load_byte = (state == ACTIVE && bus.valid_in) ? bus.data_in : IDLE_SYMBOL;

  // State register for the preamble FSM.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state    <= SYNC;
      sync_cnt <= '0;
    end else begin
      state    <= state_d;
      sync_cnt <= sync_cnt_d;
    end
  end

  // Count preamble commas and move to ACTIVE on the load of the last one.
  always_comb begin
    state_d    = state;
    sync_cnt_d = sync_cnt;
    if (state == SYNC && load) begin
      sync_cnt_d = sync_cnt + SW'(1);
      if (sync_cnt == LAST_SYNC) state_d = ACTIVE;
    end
  end

  // Shift register: load a whole byte on a load edge, else shift left.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd7;
    end else if (load) begin
      shreg   <= load_byte;
      bit_cnt <= 3'd0;
    end else begin
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign bus.data_out   = shreg[7];
  assign bus.ready_out  = (state == ACTIVE) && load;
  assign bus.active_out = (state == ACTIVE);
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_phy_tx_serial.sv
// Bench for phy_tx_serial. The reference model knows the lane's schedule:
// a load every eight edges after reset, the first SYNC_SYMBOLS loads are
// commas, and later loads take a queued byte or a comma. It predicts the
// serial byte stream, ready_out and active_out.
module tb_phy_tx_serial;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         NSYNC = 4;

  // ---------------- clock / reset ----------------
  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_8f = ~clk_8f;

  phy_tx_serial_if bus ();

  phy_tx_serial #(.IDLE_SYMBOL(COMMA), .SYNC_SYMBOLS(NSYNC)) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          edge_n;            // rising edges since reset release
  logic [7:0]  exp_q[$];          // bytes expected on the serial line, in order
  logic [8:0]  stim_q[$];         // {valid, data} offered at each ready slot
  logic [7:0]  rx_sh;
  int          rx_bits;
  bit          hold_a5 = 1'b0;    // drive valid=1/A5 outside ready slots

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  // Drive junk that must be ignored (not at a ready slot).
  task automatic drive_junk();
    if (hold_a5) begin
      bus.valid_in = 1'b1;
      bus.data_in  = 8'hA5;
    end else begin
      bus.valid_in = 1'($urandom_range(0, 1));
      bus.data_in  = 8'($urandom_range(0, 255));
    end
  endtask

  // Called at a falling edge. Runs one clock cycle.
  task automatic cycle();
    bit         is_load;
    int         slot;
    logic [8:0] s;
    logic [7:0] byte_v;
    is_load = (edge_n % 8 == 0);
    slot    = edge_n / 8;
    check("ready_out", 8'(bus.ready_out), 8'(is_load && slot >= NSYNC));
    if (is_load && slot >= NSYNC) begin
      if (stim_q.size() > 0) s = stim_q.pop_front();
      else                   s = {1'b0, 8'($urandom_range(0, 255))};
      bus.valid_in = s[8];
      bus.data_in  = s[7:0];
      byte_v       = s[8] ? s[7:0] : COMMA;
    end else begin
      drive_junk();
      byte_v = COMMA;
    end
    if (is_load) exp_q.push_back(byte_v);
    @(posedge clk_8f);
    #1;
    edge_n++;
    check("active_out", 8'(bus.active_out), 8'(edge_n >= 8 * (NSYNC - 1) + 1));
    rx_sh = {rx_sh[6:0], bus.data_out};
    rx_bits++;
    if (rx_bits == 8) begin
      rx_bits = 0;
      if (exp_q.size() == 0) check("byte_underflow", rx_sh, 8'hXX);
      else                   check("serial_byte", rx_sh, exp_q.pop_front());
    end
    @(negedge clk_8f);
  endtask

  // Assert reset (asynchronously, at the current time) and check outputs.
  // Release it at a falling edge and clear the model.
  task automatic apply_reset();
    reset = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    #1;
    check("rst_data_out", 8'(bus.data_out), 8'h00);
    check("rst_ready_out", 8'(bus.ready_out), 8'h00);
    check("rst_active_out", 8'(bus.active_out), 8'h00);
    @(posedge clk_8f);
    #1;
    check("rst_hold_data_out", 8'(bus.data_out), 8'h00);
    @(negedge clk_8f);
    reset   = 1'b0;
    edge_n  = 0;
    rx_bits = 0;
    rx_sh   = 8'h00;
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    edge_n  = 0;
    rx_bits = 0;
    rx_sh   = 8'h00;
    @(negedge clk_8f);

    // 1: idle after reset, commas forever, ready from edge 32
    apply_reset();
    run(8 * 8);

    // 2: valid=1/A5 held throughout sync, then A5 accepted at edge 33
    apply_reset();
    hold_a5 = 1'b1;
    stim_q.push_back({1'b1, 8'hA5});
    run(8 * 6);
    hold_a5 = 1'b0;

    // 3: back-to-back bytes, no idle bits between them
    apply_reset();
    stim_q.push_back({1'b1, 8'h01});
    stim_q.push_back({1'b1, 8'hFF});
    stim_q.push_back({1'b1, 8'h80});
    run(8 * 8);

    // 4: one empty slot between two bytes sends a comma
    apply_reset();
    stim_q.push_back({1'b1, 8'h3C});
    stim_q.push_back({1'b0, 8'h77});
    stim_q.push_back({1'b1, 8'hC3});
    run(8 * 8);

    // 5: reset mid-byte (bit_cnt=3 while sending 55), then full preamble again
    apply_reset();
    stim_q.push_back({1'b1, 8'h55});
    run(8 * NSYNC + 4);          // 55 loaded at edge 33, then 3 more edges
    #2;
    apply_reset();
    stim_q.push_back({1'b1, 8'h66});
    run(8 * 6);

    // random traffic: a mix of valid bytes and empty slots
    apply_reset();
    for (int i = 0; i < 40; i++)
      stim_q.push_back({1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255))});
    run(8 * (NSYNC + 40 + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", edge_n);
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
